// File: rtl/audio_rec_play_ctrl.sv
// Record/playback sequencer for the on-chip audio sample buffer: key conditioning,
// sample-rate tick, buffer write/read strobes. Build option LOOP_PLAY_EN: looping playback.
module audio_rec_play_ctrl #(
  parameter int CLK_HZ      = 50000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int RECORD_TIME = 2,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_key_n,
  input  logic              play_key_n,
  input  logic [15:0]       mic_in,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [15:0]       buf_wdata,
  output logic              buf_re,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [15:0]       buf_rdata,
  output logic [15:0]       audio_out,
  output logic              audio_valid,
  output logic [17:0]       ledr
);

  // state  | meaning
  // S_IDLE | waiting for a key press, no buffer traffic
  // S_REC  | writing mic_in to the buffer on every sample tick
  // S_PLAY | reading the buffer on every sample tick, samples go to audio_out

  localparam int DIV    = CLK_HZ / SAMPLE_RATE;
  localparam int TOTAL  = SAMPLE_RATE * RECORD_TIME;
  localparam int TCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LEN_W  = ADDR_W + 1;

  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(DIV - 1);
  localparam logic [LEN_W-1:0]  LEN_TOTAL = LEN_W'(TOTAL);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_rec_s1, r_rec_s2, r_rec_s3;
  logic r_play_s1, r_play_s2, r_play_s3;
  logic w_rec_press, w_play_press;

  logic [TCNT_W-1:0] r_tick_cnt;
  logic              w_tick;

  logic [LEN_W-1:0] r_smp_cnt;
  logic [LEN_W-1:0] r_rec_len;
  logic             r_done;
  logic             w_last_wr, w_last_rd;

  logic             w_start, w_we, w_re, w_cnt_inc, w_cnt_clr, w_done_set, w_len_ld;
  logic [LEN_W-1:0] w_len_nxt;

  logic              r_buf_we, r_buf_re, r_audio_valid;
  logic [ADDR_W-1:0] r_buf_waddr, r_buf_raddr;
  logic [15:0]       r_buf_wdata, r_audio_hold;

  // Synchronisers idle high so that reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rec_s1  <= 1'b1;
      r_rec_s2  <= 1'b1;
      r_rec_s3  <= 1'b1;
      r_play_s1 <= 1'b1;
      r_play_s2 <= 1'b1;
      r_play_s3 <= 1'b1;
    end else begin
      r_rec_s1  <= rec_key_n;
      r_rec_s2  <= r_rec_s1;
      r_rec_s3  <= r_rec_s2;
      r_play_s1 <= play_key_n;
      r_play_s2 <= r_play_s1;
      r_play_s3 <= r_play_s2;
    end
  end

  assign w_rec_press  = r_rec_s3 & ~r_rec_s2;
  assign w_play_press = r_play_s3 & ~r_play_s2;

  assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == TICK_LAST);
  assign w_last_wr = (r_smp_cnt == LEN_TOTAL - LEN_ONE);
  assign w_last_rd = (r_smp_cnt == r_rec_len - LEN_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_start || (r_state == S_IDLE) || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_done_set  = 1'b0;
    w_len_ld    = 1'b0;
    w_len_nxt   = r_rec_len;
    case (r_state)
      S_IDLE: begin
        if (w_rec_press) begin
          w_state_nxt = S_REC;
          w_start     = 1'b1;
        end else if (w_play_press && (r_rec_len != '0)) begin
          w_state_nxt = S_PLAY;
          w_start     = 1'b1;
        end
      end
      S_REC: begin
        if (w_tick) begin
          w_we      = 1'b1;
          w_cnt_inc = 1'b1;
        end
        if (w_tick && w_last_wr) begin
          w_len_ld    = 1'b1;
          w_len_nxt   = LEN_TOTAL;
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rec_press) begin
          // A write issued on this same cycle still counts toward the length.
          w_len_ld    = 1'b1;
          w_len_nxt   = w_tick ? (r_smp_cnt + LEN_ONE) : r_smp_cnt;
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PLAY: begin
        if (w_tick) begin
          w_re      = 1'b1;
          w_cnt_inc = 1'b1;
          if (w_last_rd) begin
`ifdef LOOP_PLAY_EN
            w_cnt_clr = 1'b1;
`else
            w_done_set  = 1'b1;
            w_state_nxt = S_IDLE;
`endif
          end
        end
        if (w_rec_press) begin
          w_state_nxt = S_REC;
          w_start     = 1'b1;
        end else if (w_play_press) begin
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp_cnt <= '0;
      r_rec_len <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_start || w_cnt_clr) begin
        r_smp_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_smp_cnt <= r_smp_cnt + LEN_ONE;
      end
      if (w_len_ld) begin
        r_rec_len <= w_len_nxt;
      end
      if (w_start) begin
        r_done <= 1'b0;
      end else if (w_done_set) begin
        r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_we      <= 1'b0;
      r_buf_waddr   <= '0;
      r_buf_wdata   <= '0;
      r_buf_re      <= 1'b0;
      r_buf_raddr   <= '0;
      r_audio_valid <= 1'b0;
      r_audio_hold  <= '0;
    end else begin
      r_buf_we <= w_we;
      if (w_we) begin
        r_buf_waddr <= r_smp_cnt[ADDR_W-1:0];
        r_buf_wdata <= mic_in;
      end
      r_buf_re <= w_re;
      if (w_re) begin
        r_buf_raddr <= r_smp_cnt[ADDR_W-1:0];
      end
      r_audio_valid <= r_buf_re;
      if (r_audio_valid) begin
        r_audio_hold <= buf_rdata;
      end
    end
  end

  // The RAM returns data the cycle after the read strobe, so the valid cycle
  // passes it straight through and the hold register keeps it afterwards.
  assign audio_out   = r_audio_valid ? buf_rdata : r_audio_hold;
  assign audio_valid = r_audio_valid;
  assign buf_we      = r_buf_we;
  assign buf_waddr   = r_buf_waddr;
  assign buf_wdata   = r_buf_wdata;
  assign buf_re      = r_buf_re;
  assign buf_raddr   = r_buf_raddr;
  assign ledr        = {r_done, 15'd0, (r_state == S_PLAY), (r_state == S_REC)};

endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// Bench for audio_rec_play_ctrl: directed sessions then random key/mic activity,
// checked every cycle against a session-level reference model.
module tb_audio_rec_play_ctrl;
  localparam int CLK_HZ = 8, SAMPLE_RATE = 1, RECORD_TIME = 4, ADDR_W = 3;
  localparam int DIV = CLK_HZ / SAMPLE_RATE;
  localparam int TOTAL = SAMPLE_RATE * RECORD_TIME;
  localparam int MAXC = 8192;
  localparam int M_IDLE = 0, M_REC = 1, M_PLAY = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rec_key_n = 1'b1;
  logic play_key_n = 1'b1;
  logic [15:0] mic_in = '0;
  logic buf_we, buf_re, audio_valid;
  logic [ADDR_W-1:0] buf_waddr, buf_raddr;
  logic [15:0] buf_wdata, audio_out;
  logic [15:0] buf_rdata = '0;
  logic [17:0] ledr;
  logic [15:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0, errors = 0, cyc = 0;
  int n_we = 0, n_re = 0, n_valid = 0;
  bit rand_mic = 1'b0;
  bit kr [MAXC];
  bit kp [MAXC];

  int m_mode, m_entry, m_idx, m_len, m_raddr_prev;
  bit m_done, m_re_prev;
  logic [15:0] m_hold;
  logic [15:0] m_mem [TOTAL];
  bit e_we, e_re, e_valid;
  int e_waddr, e_raddr;
  logic [15:0] e_wdata, e_aout;
  logic [17:0] e_ledr;

  always #5 clk = ~clk;

  audio_rec_play_ctrl #(.CLK_HZ(CLK_HZ), .SAMPLE_RATE(SAMPLE_RATE),
                        .RECORD_TIME(RECORD_TIME), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rec_key_n(rec_key_n), .play_key_n(play_key_n),
    .mic_in(mic_in), .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .buf_re(buf_re), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .audio_out(audio_out), .audio_valid(audio_valid), .ledr(ledr));

  // Synchronous-read buffer RAM.
  always @(posedge clk) begin
    if (buf_we) ram[buf_waddr] <= buf_wdata;
    if (buf_re) buf_rdata <= ram[buf_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_entry = 0; m_idx = 0; m_len = 0; m_done = 1'b0;
    m_re_prev = 1'b0; m_raddr_prev = 0; m_hold = '0;
    e_ledr = '0;
  endtask

  task automatic model_start(input int mode);
    m_mode = mode; m_entry = cyc; m_idx = 0; m_done = 1'b0;
  endtask

  // Expected outputs after edge number cyc; a press acts 3 edges after the key drops.
  task automatic model_edge(input logic [15:0] mic);
    bit rp, pp, tick;
    rp = (cyc >= 4) && (kr[cyc-3] == 1'b0) && (kr[cyc-4] == 1'b1);
    pp = (cyc >= 4) && (kp[cyc-3] == 1'b0) && (kp[cyc-4] == 1'b1);
    e_valid = m_re_prev;
    if (m_re_prev) begin
      e_aout = m_mem[m_raddr_prev];
      m_hold = e_aout;
    end else begin
      e_aout = m_hold;
    end
    e_we = 1'b0; e_re = 1'b0;
    tick = (m_mode != M_IDLE) && (cyc > m_entry) && (((cyc - m_entry) % DIV) == 0);
    if (m_mode == M_IDLE) begin
      if (rp) model_start(M_REC);
      else if (pp && m_len != 0) model_start(M_PLAY);
    end else if (m_mode == M_REC) begin
      if (tick) begin
        e_we = 1'b1; e_waddr = m_idx; e_wdata = mic; m_mem[m_idx] = mic; m_idx++;
      end
      if (m_idx == TOTAL || rp) begin
        m_len = m_idx; m_done = 1'b1; m_mode = M_IDLE;
      end
    end else begin
      if (tick) begin
        e_re = 1'b1; e_raddr = m_idx; m_idx++;
      end
      if (rp) model_start(M_REC);
      else if (pp) begin m_done = 1'b1; m_mode = M_IDLE; end
      else if (m_idx == m_len) begin
`ifdef LOOP_PLAY_EN
        m_idx = 0;
`else
        m_done = 1'b1; m_mode = M_IDLE;
`endif
      end
    end
    m_re_prev = e_re;
    m_raddr_prev = e_raddr;
    e_ledr = {m_done, 15'd0, (m_mode == M_PLAY), (m_mode == M_REC)};
  endtask

  task automatic check_outputs();
    chk("we", 32'(buf_we), 32'(e_we));
    chk("re", 32'(buf_re), 32'(e_re));
    chk("we_re_excl", 32'(buf_we & buf_re), 32'd0);
    if (e_we) begin
      chk("waddr", 32'(buf_waddr), 32'(e_waddr));
      chk("wdata", 32'(buf_wdata), 32'(e_wdata));
    end
    if (e_re) chk("raddr", 32'(buf_raddr), 32'(e_raddr));
    chk("valid", 32'(audio_valid), 32'(e_valid));
    chk("audio_out", 32'(audio_out), 32'(e_aout));
    chk("ledr", 32'(ledr), 32'(e_ledr));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, 32'(buf_we), 32'd0);
    chk({tag, "_waddr"}, 32'(buf_waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(buf_wdata), 32'd0);
    chk({tag, "_re"}, 32'(buf_re), 32'd0);
    chk({tag, "_raddr"}, 32'(buf_raddr), 32'd0);
    chk({tag, "_aout"}, 32'(audio_out), 32'd0);
    chk({tag, "_valid"}, 32'(audio_valid), 32'd0);
    chk({tag, "_ledr"}, 32'(ledr), 32'd0);
  endtask

  task automatic step();
    logic [15:0] mic_prev;
    if (rand_mic) mic_in = 16'($urandom);
    else mic_in = 16'h1000 + 16'(n_we);
    mic_prev = mic_in;
    kr[cyc] = rec_key_n;
    kp[cyc] = play_key_n;
    @(posedge clk); #1;
    cyc++;
    if (buf_we) n_we++;
    if (buf_re) n_re++;
    if (audio_valid) n_valid++;
    model_edge(mic_prev);
    check_outputs();
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input bit r, input bit p, input int hold);
    if (r) rec_key_n = 1'b0;
    if (p) play_key_n = 1'b0;
    step_n(hold);
    rec_key_n = 1'b1;
    play_key_n = 1'b1;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      kr[cyc] = 1'b1; kp[cyc] = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    reset_cycles(3);
    rst_n = 1'b1;
    model_reset();
    check_zero("reset");

    // Play with nothing recorded is ignored.
    press(0, 1, 2); step_n(10);
    chk("empty_play_ledr", 32'(ledr), 32'd0);

    // Full recording of samples 0x1000..0x1003.
    n_we = 0;
    press(1, 0, 2); step_n(40);
    chk("full_nwe", 32'(n_we), 32'd4);
    chk("full_ledr", 32'(ledr), 32'h20000);

    // Playback of the full recording.
    n_re = 0; n_valid = 0;
    press(0, 1, 2); step_n(40);
`ifndef LOOP_PLAY_EN
    chk("play_nre", 32'(n_re), 32'd4);
    chk("play_nvalid", 32'(n_valid), 32'd4);
    chk("play_last_sample", 32'(audio_out), 32'h1003);
    chk("play_ledr", 32'(ledr), 32'h20000);
`else
    press(0, 1, 2); step_n(6);
    chk("loop_stop_ledr", 32'(ledr), 32'h20000);
`endif

    // Early stop after two writes.
    n_we = 0;
    press(1, 0, 2); step_n(17);
    press(1, 0, 2); step_n(8);
    chk("early_nwe", 32'(n_we), 32'd2);
    chk("early_ledr", 32'(ledr), 32'h20000);
    n_re = 0;
    press(0, 1, 2); step_n(30);
`ifndef LOOP_PLAY_EN
    chk("early_play_nre", 32'(n_re), 32'd2);
`else
    press(0, 1, 2); step_n(5);
    chk("loop_nre", 32'(n_re), 32'd4);
`endif

    // Simultaneous presses: record wins.
    n_re = 0;
    press(1, 1, 2); step_n(2);
    chk("prio_ledr", 32'(ledr), 32'h1);
    step_n(40);
    chk("prio_nre", 32'(n_re), 32'd0);

    // Playback aborted by record.
    press(0, 1, 2); step_n(12);
    press(1, 0, 2); step_n(2);
    chk("abort_ledr", 32'(ledr), 32'h1);
    n_we = 0;
    step_n(7);
    chk("abort_nwe", 32'(n_we), 32'd1);

    // Asynchronous reset in the middle of a recording.
    step_n(5);
    #3 rst_n = 1'b0;
    #1 check_zero("arst");
    reset_cycles(2);
    rst_n = 1'b1;
    model_reset();
    n_re = 0;
    press(0, 1, 2); step_n(10);
    chk("post_rst_ledr", 32'(ledr), 32'd0);
    chk("post_rst_nre", 32'(n_re), 32'd0);

    // Random key and sample activity.
    rand_mic = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (rec_key_n && $urandom_range(0, 60) == 0) rec_key_n = 1'b0;
      else if (!rec_key_n && $urandom_range(0, 2) == 0) rec_key_n = 1'b1;
      if (play_key_n && $urandom_range(0, 40) == 0) play_key_n = 1'b0;
      else if (!play_key_n && $urandom_range(0, 2) == 0) play_key_n = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_rec_play_ctrl.md
Name: audio_rec_play_ctrl

Overview:
- Sequencer for the on-chip audio sample buffer.
- Turns two DE2 push-keys into record and playback sessions and generates the sample-rate tick.
- Drives the buffer's write port (from mic_in) and read port (to audio_out), with priority arbitration between record and play.
- Sits between the codec sample interface, the buffer RAM and the board status LEDs.

Parameters:
- CLK_HZ, 50000000: system clock frequency.
- SAMPLE_RATE, 48000: samples per second.
- RECORD_TIME, 2: maximum recording length in seconds.
- ADDR_W, 17: buffer address width; must satisfy 2^ADDR_W >= SAMPLE_RATE*RECORD_TIME.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rec_key_n  in  1  record key, active low, asynchronous to clk.
- play_key_n  in  1  play key, active low, asynchronous to clk.
- mic_in  in  16  current audio sample from codec.
- buf_we  out  1  buffer write strobe, one cycle.
- buf_waddr  out  ADDR_W  write address.
- buf_wdata  out  16  write data.
- buf_re  out  1  buffer read strobe, one cycle.
- buf_raddr  out  ADDR_W  read address.
- buf_rdata  in  16  read data, valid 1 cycle after buf_re.
- audio_out  out  16  playback sample, held between updates.
- audio_valid  out  1  one-cycle pulse when audio_out updates.
- ledr  out  18  status LEDs.

Behaviour:
- Derived constants: DIV = CLK_HZ/SAMPLE_RATE (integer division; 1041 at defaults); TOTAL = SAMPLE_RATE*RECORD_TIME (96000).
- Reset (async assert, sync release): state IDLE; all outputs 0; rec_len 0; tick counter 0; sample counter 0; done flag 0.
- Key conditioning: each key passes through a 2-FF synchroniser, then a falling-edge detector that yields a one-cycle press pulse. A pulse appears 3 clk after the key input falls. Holding a key produces no repeat pulses.
- Tick: the counter runs only in REC and PLAY, cleared to 0 on entry to either state. tick = (count == DIV-1), after which the counter wraps to 0. First tick comes DIV cycles after state entry.
- States: IDLE, REC, PLAY.
- IDLE:
  - rec press -> REC: sample counter 0, done flag 0.
  - play press with rec_len != 0 -> PLAY: sample counter 0, done flag 0.
  - play press with rec_len == 0 -> ignored.
  - Simultaneous rec and play presses -> REC wins.
- REC:
  - On each tick: buf_we=1, buf_waddr=counter, buf_wdata=mic_in (sampled that cycle), counter++.
  - On the tick that writes address TOTAL-1: rec_len=TOTAL, done=1, -> IDLE.
  - rec press (no tick the same cycle): stop early, rec_len=counter (may be 0), done=1, -> IDLE.
  - rec press coinciding with a tick: the write completes and counts first.
  - play press: ignored.
- PLAY:
  - On each tick: buf_re=1, buf_raddr=counter, counter++.
  - Next cycle: audio_out=buf_rdata, audio_valid=1.
  - After issuing the read of address rec_len-1: -> IDLE, done=1. The final audio_valid still fires one cycle later.
  - play press: stop, done=1, -> IDLE. A read already issued still completes.
  - rec press: abort playback (done stays 0), -> REC, counter cleared.
- ledr:
  - [0] = in REC; [1] = in PLAY; [17] = done flag; [16:2] = 0.
  - done clears on the next REC or PLAY entry.
- buf_we and buf_re are never both 1 in the same cycle.
- Reset mid-session: everything returns to reset values immediately. Buffer contents are not touched; rec_len is lost.

Optional Feature:
- Macro: LOOP_PLAY_EN.
- Defined: in PLAY, after reading address rec_len-1 the counter wraps to 0 and playback continues; exit only via play press (done=1) or rec press.
- Undefined: playback is single-shot as described above.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=8, SAMPLE_RATE=1, RECORD_TIME=4 (DIV=8, TOTAL=4).
- Record full: after reset, pulse rec_key_n low, mic_in=16'h1000+n. Required: 4 buf_we pulses, 8 cycles apart, addresses 0..3, data matching mic_in; then ledr=18'h20000 and rec_len=4.
- Play after full record (model RAM echoing the recorded data): play press -> 4 buf_re pulses on addresses 0..3, each followed 1 cycle later by audio_valid with audio_out=16'h1000..16'h1003; state returns to IDLE and ledr[17]=1.
- Early stop: rec press, then a second rec press after 2 writes -> rec_len=2, done=1. A later play issues exactly 2 reads.
- Priority: rec and play pressed in the same cycle from IDLE -> REC (ledr[0]=1, no buf_re). A play press before any recording (rec_len=0) -> stays IDLE, ledr=0.
- Play interrupted by record: during PLAY, rec press -> ledr=18'h1, next buf_we at address 0, done=0.
- Reset: rst_n low mid-REC -> all outputs 0 asynchronously. After release, a play press is ignored because rec_len=0.
- LOOP_PLAY_EN defined: after recording 2 samples, play gives reads on addresses 0,1,0,1,... until a play press.
